pipelined_logic_reducer: RTL and testbench
==========================================

// Module: pipelined_logic_reducer
// PURPOSE
//  Parametrised 3-stage pipelined two-level logic reducer with valid/ready flow control.
//  Per-term reduction of TERM_SIZE inputs, then a cross-term reduction of NUM_TERMS terms.
//  Both levels operate bitwise on WIDTH lanes.
//  Per-beat mode: SOP (AND terms, OR across) or POS (OR terms, AND across).
//  Sits between a streaming producer and consumer; backpressure and flush make it safe to stall.
// PARAMETERS
//  WIDTH      1  bitwise lanes per input operand
//  NUM_TERMS  2  number of first-level terms (>=1)
//  TERM_SIZE  2  operands per term (>=1)
// PORTS
//  clk        in   1                         clock, all state on posedge
//  rst_n      in   1                         asynchronous, active-low reset
//  flush      in   1                         sync clear of all pipeline valids
//  in_valid   in   1                         input beat valid
//  in_ready   out  1                         input beat accepted when in_valid&&in_ready
//  in_mode    in   1                         0=SOP, 1=POS; travels with beat
//  in_data    in   NUM_TERMS*TERM_SIZE*WIDTH operand (t*TERM_SIZE+j)*WIDTH+w = term t, operand j, lane w
//  out_valid  out  1                         result valid
//  out_ready  in   1                         consumer accepts when out_valid&&out_ready
//  out_data   out  WIDTH                     reduced result
// BEHAVIOUR
//  Single clock domain; one async active-low reset; clock and reset are clk and rst_n.
//  Reset: all stage valids=0, all data/mode regs=0; out_valid=0, out_data=0.
//   in_ready=1 once rst_n deasserts.
//  Stages:
//   S0 registers in_data/in_mode.
//   S1 registers per-term result: AND of TERM_SIZE operands (SOP) or OR (POS), NUM_TERMS*WIDTH bits.
//   S2 registers final: OR across terms (SOP) or AND (POS) -> out_data.
//  Stage load rule:
//   stage i loads when !v[i] || ld[i+1]; S2 loads when !v2 || out_ready.
//   in_ready = (!v0 || ld1) && !flush, combinational.
//   Data regs update only on load; v[i] <= v[i-1] on load (S0: in_valid&&in_ready).
//  Latency: beat accepted at edge N is presented on out_* from edge N+2 with no stall.
//  Throughput: 1 beat/cycle when out_ready held high.
//  Order preserved; no beat dropped or duplicated under any out_ready pattern.
//  Stall: out_valid=1 && out_ready=0 -> out_data/out_valid hold stable.
//   Upstream stages fill; in_ready drops only when S0..S2 all valid.
//  Simultaneous in accept and out accept in the same cycle with a full pipe: allowed, no bubble.
//  flush=1:
//   - clears v0,v1,v2 at next edge; out_valid=0 the following cycle.
//   - in_ready=0, so no beat is accepted that cycle.
//   - A concurrent out handshake still counts as delivered.
//  Mode is per beat: mixed SOP/POS beats back-to-back each reduce with their own mode.
//  Degenerate sizes:
//   - TERM_SIZE=1: term = operand.
//   - NUM_TERMS=1: out = term result.
//  Reset asserted mid-stream: immediate clear of all valids and data, in-flight beats lost.
//  out_valid low asynchronously.
// STRUCTURE
//  Package logic_reducer_pkg:
//   - typedef enum logic {MODE_SOP=1'b0, MODE_POS=1'b1} reduce_mode_e
//   - constant LATENCY=3
//  Sub-module pipe_stage #(W):
//   - generic valid/ready register slice (v, data, load rule, flush, async reset).
//   - instantiated 3 times with W = 1+N*T*WIDTH, 1+N*WIDTH, WIDTH.
//  Reduction logic is combinational between slices, built with generate loops over terms and lanes.
// TESTING
//  1. WIDTH=1,N=2,T=2, SOP, data {d,c,b,a}=4'b0011, out_ready=1 -> out_data=1 exactly 2 cycles after accept.
//  2. Same params, POS, 4'b0101 -> (a|b)&(c|d)=1; POS 4'b0011 -> 0; back-to-back, results in order.
//  3. WIDTH=8,N=4,T=3, 20 random beats, out_ready random 50% -> scoreboard match, out_data stable while stalled, no loss.
//  4. out_ready=0, push 4 beats -> 3 accepted, in_ready=0 on 4th; raise out_ready -> 3 beats out in order, 4th accepted.
//  5. Pipe full, assert flush 1 cycle with in_valid=1 -> in_ready=0, out_valid=0 next cycle, flushed beats never appear.
//  6. Drop rst_n mid-stream asynchronously -> out_valid=0 immediately, out_data=0.
//   After release, first new beat appears at latency 2.

Source files
------------

// File: rtl/pipelined_logic_reducer_pkg.sv
// Shared types and constants for the pipelined two-level logic reducer.
package logic_reducer_pkg;

  // Per-beat reduction mode.
  // SOP reduces each term with AND and combines the terms with OR.
  // POS reduces each term with OR and combines the terms with AND.
  typedef enum logic {
    MODE_SOP = 1'b0,
    MODE_POS = 1'b1
  } reduce_mode_e;

  // Number of register slices between in_* and out_*.
  localparam int unsigned LATENCY = 3;

endpackage

// File: rtl/pipelined_logic_reducer_pipe_stage.sv
// Generic valid/ready register slice with flush and async reset.
module pipe_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  input  logic         down_ready,
  output logic         ld_c,
  output logic         v,
  output logic [W-1:0] d
);

  // The slice can take a new beat when it is empty or its beat leaves this cycle.
  assign ld_c = !v || down_ready;

  // Valid bit: flush empties the slice; otherwise follow upstream on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ld_c) begin
      v <= v_in;
    end
  end

  // Payload only changes on load, so a stalled beat holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
    end else if (ld_c) begin
      d <= d_in;
    end
  end

endmodule

// File: rtl/pipelined_logic_reducer.sv
// Three-slice streaming reducer: capture, per-term reduce, cross-term reduce.
module pipelined_logic_reducer
  import logic_reducer_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned NUM_TERMS = 2,
  parameter int unsigned TERM_SIZE = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_mode,
  input  logic [NUM_TERMS*TERM_SIZE*WIDTH-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0]                     out_data
);

  localparam int unsigned OPS_W  = NUM_TERMS * TERM_SIZE * WIDTH;
  localparam int unsigned TERM_W = NUM_TERMS * WIDTH;
  localparam int unsigned S0_W   = 1 + OPS_W;
  localparam int unsigned S1_W   = 1 + TERM_W;

  logic              s0_v, s1_v, s2_v;
  logic              s0_ld_c, s1_ld_c, s2_ld_c;
  logic [S0_W-1:0]   s0_d;
  logic [S1_W-1:0]   s1_d;
  logic [WIDTH-1:0]  s2_d;

  logic              s0_mode;
  logic [OPS_W-1:0]  s0_ops;
  logic              s1_mode;
  logic [TERM_W-1:0] s1_terms;
  logic [TERM_W-1:0] term_c;
  logic [WIDTH-1:0]  final_c;
  logic              accept_c;

  // Flush blocks acceptance so nothing enters a pipe that is being emptied.
  assign in_ready = s0_ld_c && !flush;
  assign accept_c = in_valid && in_ready;

  assign s0_mode  = s0_d[S0_W-1];
  assign s0_ops   = s0_d[OPS_W-1:0];
  assign s1_mode  = s1_d[S1_W-1];
  assign s1_terms = s1_d[TERM_W-1:0];

  // Slice 0: capture the incoming operands with their mode.
  pipe_stage #(.W(S0_W)) u_s0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .v_in       (accept_c),
    .d_in       ({in_mode, in_data}),
    .down_ready (s1_ld_c),
    .ld_c       (s0_ld_c),
    .v          (s0_v),
    .d          (s0_d)
  );

  // First level: reduce the TERM_SIZE operands of each term, lane by lane.
  for (genvar t = 0; t < int'(NUM_TERMS); t++) begin : g_term
    for (genvar w = 0; w < int'(WIDTH); w++) begin : g_lane
      logic acc;
      // AND-reduce for SOP, OR-reduce for POS; a single operand passes through.
      always_comb begin
        acc = (reduce_mode_e'(s0_mode) == MODE_POS) ? 1'b0 : 1'b1;
        for (int j = 0; j < int'(TERM_SIZE); j++) begin
          if (reduce_mode_e'(s0_mode) == MODE_POS) begin
            acc = acc | s0_ops[(t*int'(TERM_SIZE)+j)*int'(WIDTH)+w];
          end else begin
            acc = acc & s0_ops[(t*int'(TERM_SIZE)+j)*int'(WIDTH)+w];
          end
        end
      end
      assign term_c[t*int'(WIDTH)+w] = acc;
    end
  end

  // Slice 1: per-term results with the mode still attached.
  pipe_stage #(.W(S1_W)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .v_in       (s0_v),
    .d_in       ({s0_mode, term_c}),
    .down_ready (s2_ld_c),
    .ld_c       (s1_ld_c),
    .v          (s1_v),
    .d          (s1_d)
  );

  // Second level: combine the terms per lane; a single term passes through.
  for (genvar w = 0; w < int'(WIDTH); w++) begin : g_cross
    logic acc;
    // OR across terms for SOP, AND across terms for POS.
    always_comb begin
      acc = (reduce_mode_e'(s1_mode) == MODE_POS) ? 1'b1 : 1'b0;
      for (int t = 0; t < int'(NUM_TERMS); t++) begin
        if (reduce_mode_e'(s1_mode) == MODE_POS) begin
          acc = acc & s1_terms[t*int'(WIDTH)+w];
        end else begin
          acc = acc | s1_terms[t*int'(WIDTH)+w];
        end
      end
    end
    assign final_c[w] = acc;
  end

  // Slice 2: final result presented to the consumer.
  pipe_stage #(.W(WIDTH)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .v_in       (s1_v),
    .d_in       (final_c),
    .down_ready (out_ready),
    .ld_c       (s2_ld_c),
    .v          (s2_v),
    .d          (s2_d)
  );

  assign out_valid = s2_v;
  assign out_data  = s2_d;

endmodule

// File: tb/tb_pipelined_logic_reducer.sv
// Directed bench for the pipelined logic reducer (small and wide configurations).
module tb_pipelined_logic_reducer;

  logic clk;
  logic rst_n;

  // Small instance: WIDTH=1, NUM_TERMS=2, TERM_SIZE=2.
  logic       a_flush, a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
  logic [3:0] a_in_data;
  logic [0:0] a_out_data;

  // Wide instance: WIDTH=8, NUM_TERMS=4, TERM_SIZE=3.
  logic        b_flush, b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic [95:0] b_in_data;
  logic [7:0]  b_out_data;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] exp_q[$];
  logic       b_acc_seen;
  logic       b_rdy_seen;
  logic       prev_stall;
  logic [7:0] prev_data;
  int         acc_n;

  pipelined_logic_reducer #(.WIDTH(1), .NUM_TERMS(2), .TERM_SIZE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  pipelined_logic_reducer #(.WIDTH(8), .NUM_TERMS(4), .TERM_SIZE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference reduction for the wide instance, operand index (t*3+j)*8+w.
  function automatic logic [7:0] model_b(input logic md, input logic [95:0] d);
    logic [7:0] r;
    logic term, acc;
    for (int w = 0; w < 8; w++) begin
      acc = md;
      for (int t = 0; t < 4; t++) begin
        term = ~md;
        for (int j = 0; j < 3; j++) begin
          if (md) term = term | d[(t*3+j)*8+w];
          else    term = term & d[(t*3+j)*8+w];
        end
        if (md) acc = acc & term;
        else    acc = acc | term;
      end
      r[w] = acc;
    end
    return r;
  endfunction

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One cycle on the wide instance: drive, score handshakes, advance past the edge.
  task automatic cyc_b(input logic iv, input logic md, input logic [95:0] dt,
                       input logic ordy, input logic fl);
    if (prev_stall) begin
      chk("stall_valid_hold", 96'(b_out_valid), 96'(1'b1));
      chk("stall_data_hold", 96'(b_out_data), 96'(prev_data));
    end
    b_in_valid  = iv;
    b_in_mode   = md;
    b_in_data   = dt;
    b_out_ready = ordy;
    b_flush     = fl;
    #1;
    b_rdy_seen = b_in_ready;
    b_acc_seen = b_in_valid && b_in_ready;
    if (b_out_valid && b_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 96'(b_out_data), 96'hDEAD);
      end else begin
        chk("scoreboard_data", 96'(b_out_data), 96'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (fl) exp_q.delete();
    if (b_acc_seen) exp_q.push_back(model_b(md, dt));
    prev_stall = !fl && b_out_valid && !b_out_ready;
    prev_data  = b_out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1;
    prev_stall = 0; prev_data = '0; b_acc_seen = 0; b_rdy_seen = 0; acc_n = 0;

    // Reset state
    #12;
    chk("rst_a_valid", 96'(a_out_valid), 96'(1'b0));
    chk("rst_a_data", 96'(a_out_data), 96'(1'b0));
    chk("rst_b_valid", 96'(b_out_valid), 96'(1'b0));
    chk("rst_b_data", 96'(b_out_data), 96'(8'h00));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_a_ready", 96'(a_in_ready), 96'(1'b1));
    chk("rst_b_ready", 96'(b_in_ready), 96'(1'b1));

    // Test 1: SOP 4'b0011 -> 1, two cycles after accept
    a_in_valid = 1; a_in_mode = 0; a_in_data = 4'b0011;
    #1;
    chk("t1_in_ready", 96'(a_in_ready), 96'(1'b1));
    @(posedge clk); #1;
    a_in_valid = 0;
    chk("t1_lat_n0", 96'(a_out_valid), 96'(1'b0));
    @(posedge clk); #1;
    chk("t1_lat_n1", 96'(a_out_valid), 96'(1'b0));
    @(posedge clk); #1;
    chk("t1_lat_n2_valid", 96'(a_out_valid), 96'(1'b1));
    chk("t1_lat_n2_data", 96'(a_out_data), 96'(1'b1));
    @(posedge clk); #1;
    chk("t1_drained", 96'(a_out_valid), 96'(1'b0));

    // Test 2: back-to-back POS 0101 -> 1, POS 0011 -> 0, then SOP 0110 -> 0
    a_in_valid = 1; a_in_mode = 1; a_in_data = 4'b0101;
    @(posedge clk); #1;
    a_in_mode = 1; a_in_data = 4'b0011;
    @(posedge clk); #1;
    a_in_mode = 0; a_in_data = 4'b0110;
    @(posedge clk); #1;
    a_in_valid = 0;
    chk("t2_b0_valid", 96'(a_out_valid), 96'(1'b1));
    chk("t2_b0_data", 96'(a_out_data), 96'(1'b1));
    @(posedge clk); #1;
    chk("t2_b1_valid", 96'(a_out_valid), 96'(1'b1));
    chk("t2_b1_data", 96'(a_out_data), 96'(1'b0));
    @(posedge clk); #1;
    chk("t2_b2_valid", 96'(a_out_valid), 96'(1'b1));
    chk("t2_b2_data", 96'(a_out_data), 96'(1'b0));
    @(posedge clk); #1;
    chk("t2_drained", 96'(a_out_valid), 96'(1'b0));

    // Test 3: 20 random beats under random backpressure
    for (int c = 0; c < 600 && acc_n < 20; c++) begin
      cyc_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd96(),
            1'($urandom_range(0, 1)), 1'b0);
      if (b_acc_seen) acc_n++;
    end
    chk("t3_accepted", 96'(acc_n), 96'(20));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cyc_b(0, 0, '0, 1, 0);
    chk("t3_all_delivered", 96'(exp_q.size()), 96'(0));
    cyc_b(0, 0, '0, 1, 0);

    // Test 4: out_ready low, push four beats; only three fit
    cyc_b(1, 0, {96{1'b1}}, 0, 0);
    chk("t4_rdy_a", 96'(b_rdy_seen), 96'(1'b1));
    cyc_b(1, 1, 96'h0, 0, 0);
    chk("t4_rdy_b", 96'(b_rdy_seen), 96'(1'b1));
    cyc_b(1, 0, {24'hFFFFFF, 72'h0}, 0, 0);
    chk("t4_rdy_c", 96'(b_rdy_seen), 96'(1'b1));
    cyc_b(1, 1, {{3{16'h0, 8'hFF}}, 16'h0, 8'hFF}, 0, 0);
    chk("t4_rdy_d_full", 96'(b_rdy_seen), 96'(1'b0));
    chk("t4_full_valid", 96'(b_out_valid), 96'(1'b1));
    chk("t4_full_data", 96'(b_out_data), 96'(8'hFF));
    cyc_b(1, 1, {{3{16'h0, 8'hFF}}, 16'h0, 8'hFF}, 1, 0);
    chk("t4_rdy_d_accept", 96'(b_rdy_seen), 96'(1'b1));
    chk("t4_b_next", 96'(b_out_data), 96'(8'h00));
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) cyc_b(0, 0, '0, 1, 0);
    chk("t4_all_delivered", 96'(exp_q.size()), 96'(0));

    // Test 5: flush a full pipe with a beat offered
    cyc_b(1, 0, rnd96(), 0, 0);
    cyc_b(1, 1, rnd96(), 0, 0);
    cyc_b(1, 0, rnd96(), 0, 0);
    cyc_b(1, 1, rnd96(), 0, 1);
    chk("t5_flush_rdy", 96'(b_rdy_seen), 96'(1'b0));
    chk("t5_flush_valid", 96'(b_out_valid), 96'(1'b0));
    for (int c = 0; c < 5; c++) cyc_b(0, 0, '0, 1, 0);
    chk("t5_nothing_after", 96'(b_out_valid), 96'(1'b0));

    // Test 6: async reset mid-stream, then latency 2 for the next beat
    cyc_b(1, 0, {96{1'b1}}, 0, 0);
    cyc_b(1, 1, rnd96(), 0, 0);
    cyc_b(1, 0, {96{1'b1}}, 0, 0);
    b_in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 96'(b_out_valid), 96'(1'b0));
    chk("t6_rst_data", 96'(b_out_data), 96'(8'h00));
    exp_q.delete();
    prev_stall = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc_b(1, 0, {96{1'b1}}, 1, 0);
    chk("t6_lat_n0", 96'(b_out_valid), 96'(1'b0));
    cyc_b(0, 0, '0, 1, 0);
    chk("t6_lat_n1", 96'(b_out_valid), 96'(1'b0));
    cyc_b(0, 0, '0, 1, 0);
    chk("t6_lat_n2_valid", 96'(b_out_valid), 96'(1'b1));
    chk("t6_lat_n2_data", 96'(b_out_data), 96'(8'hFF));
    cyc_b(0, 0, '0, 1, 0);
    chk("t6_drained", 96'(exp_q.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
